// File: rtl/mips_pkg.sv
// Shared MIPS pipeline types: control bundle and inter-stage register layouts.
package mips_pkg;

    typedef struct packed {
        logic       regwrite;
        logic       memtoreg;
        logic       memwrite;
        logic       branch;
        logic       bne;
        logic       alusrc;
        logic       regdst;
        logic [2:0] alucontrol;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pcplus4;
        logic        valid;
    } fd_t;

    typedef struct packed {
        ctrl_t       ctrl;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] signimm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        valid;
    } de_t;

    localparam int FD_W = $bits(fd_t);
    localparam int DE_W = $bits(de_t);

endpackage

// File: rtl/pipeline_regs_flopenrc.sv
// Enabled register with synchronous clear and synchronous active-low reset.
module flopenrc #(
    parameter int               WIDTH     = 32,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] q_q;

    // Clear only acts when enabled, so a held stage ignores clear requests.
    always_comb begin
        q_d = q_q;
        if (en) q_d = clr ? '0 : d;
    end

    always_ff @(posedge clk) begin
        if (!reset) q_q <= RESET_VAL;
        else        q_q <= q_d;
    end

    assign q = q_q;

endmodule

// File: rtl/pipeline_regs.sv
// PC, F/D and D/E pipeline registers with stall/flush event counters.
module pipeline_regs
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stallF,
    input  logic             stallD,
    input  logic             flushE,
    input  logic             pcsrcD,
    input  logic             jumpD,
    input  logic [31:0]      pcnextF,
    input  logic [31:0]      instrF,
    input  logic [31:0]      pcplus4F,
    input  ctrl_t            ctrlD,
    input  logic [31:0]      rd1D,
    input  logic [31:0]      rd2D,
    input  logic [31:0]      signimmD,
    input  logic [4:0]       rsD,
    input  logic [4:0]       rtD,
    input  logic [4:0]       rdD,
    output logic [31:0]      pcF,
    output logic [31:0]      instrD,
    output logic [31:0]      pcplus4D,
    output logic             validD,
    output ctrl_t            ctrlE,
    output logic [31:0]      rd1E,
    output logic [31:0]      rd2E,
    output logic [31:0]      signimmE,
    output logic [4:0]       rsE,
    output logic [4:0]       rtE,
    output logic [4:0]       rdE,
    output logic             validE,
    output logic [CNT_W-1:0] stallcnt,
    output logic [CNT_W-1:0] flushcnt
);

    logic            redirect;
    logic            fd_clear;
    fd_t             fd_in;
    fd_t             fd_out;
    de_t             de_in;
    de_t             de_out;
    logic [FD_W-1:0] fd_q;
    logic [DE_W-1:0] de_q;

    assign redirect = pcsrcD | jumpD;
    assign fd_clear = redirect & ~stallD;

    flopenrc #(.WIDTH(32), .RESET_VAL(RESET_PC)) u_pc (
        .clk   (clk),
        .reset (reset),
        .en    (~stallF),
        .clr   (1'b0),
        .d     (pcnextF),
        .q     (pcF)
    );

    always_comb begin
        fd_in         = '0;
        fd_in.instr   = instrF;
        fd_in.pcplus4 = pcplus4F;
        fd_in.valid   = 1'b1;
    end

    flopenrc #(.WIDTH(FD_W)) u_fd (
        .clk   (clk),
        .reset (reset),
        .en    (~stallD),
        .clr   (redirect),
        .d     (fd_in),
        .q     (fd_q)
    );

    assign fd_out   = fd_t'(fd_q);
    assign instrD   = fd_out.instr;
    assign pcplus4D = fd_out.pcplus4;
    assign validD   = fd_out.valid;

    always_comb begin
        de_in         = '0;
        de_in.ctrl    = ctrlD;
        de_in.rd1     = rd1D;
        de_in.rd2     = rd2D;
        de_in.signimm = signimmD;
        de_in.rs      = rsD;
        de_in.rt      = rtD;
        de_in.rd      = rdD;
        de_in.valid   = validD;
    end

    // A flush clears every field, so the bubble never matches a forwarding source.
    flopenrc #(.WIDTH(DE_W)) u_de (
        .clk   (clk),
        .reset (reset),
        .en    (1'b1),
        .clr   (flushE),
        .d     (de_in),
        .q     (de_q)
    );

    assign de_out   = de_t'(de_q);
    assign ctrlE    = de_out.ctrl;
    assign rd1E     = de_out.rd1;
    assign rd2E     = de_out.rd2;
    assign signimmE = de_out.signimm;
    assign rsE      = de_out.rs;
    assign rtE      = de_out.rt;
    assign rdE      = de_out.rd;
    assign validE   = de_out.valid;

    logic [CNT_W-1:0] stallcnt_d, stallcnt_q;
    logic [CNT_W-1:0] flushcnt_d, flushcnt_q;

    always_comb begin
        stallcnt_d = stallcnt_q;
        flushcnt_d = flushcnt_q;
        if (stallD && stallcnt_q != '1)
            stallcnt_d = stallcnt_q + CNT_W'(1);
        if ((flushE || fd_clear) && flushcnt_q != '1)
            flushcnt_d = flushcnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            stallcnt_q <= '0;
            flushcnt_q <= '0;
        end else begin
            stallcnt_q <= stallcnt_d;
            flushcnt_q <= flushcnt_d;
        end
    end

    assign stallcnt = stallcnt_q;
    assign flushcnt = flushcnt_q;

endmodule

// File: doc/pipeline_regs.md
PIPELINE_REGS -- requirements
Module: pipeline_regs

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, PC value loaded on reset.
REQ-002 Parameter CNT_W, default 16, width of stall and flush event counters.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-low reset.
REQ-005 stallF, stallD, flushE  in  1 each  hazard-unit controls.
REQ-006 pcsrcD, jumpD  in  1 each  D-stage redirect (taken branch/bne, jump).
REQ-007 pcnextF  in  32  next PC selected in F.
REQ-008 instrF, pcplus4F  in  32 each  fetched word and PC+4.
REQ-009 ctrlD  in  ctrl_t  decoded control bundle.
REQ-010 rd1D, rd2D, signimmD  in  32 each  D-stage operands.
REQ-011 rsD, rtD, rdD  in  5 each  D-stage register fields.
REQ-012 pcF  out  32  current PC.
REQ-013 instrD, pcplus4D  out  32 each; validD  out  1.
REQ-014 ctrlE  out  ctrl_t; rd1E, rd2E, signimmE  out  32 each; rsE, rtE, rdE  out  5 each; validE  out  1.
REQ-015 stallcnt, flushcnt  out  CNT_W each  event counters.

Function
REQ-016 PC register SHALL load pcnextF each cycle when stallF=0 and SHALL hold when stallF=1.
REQ-017 F/D register SHALL load instrF, pcplus4F and set validD=1 when stallD=0 and no redirect.
REQ-018 When stallD=1, F/D SHALL hold all fields, irrespective of pcsrcD/jumpD.
REQ-019 When stallD=0 and (pcsrcD|jumpD)=1, F/D SHALL clear: instrD=0, pcplus4D=0, validD=0.
REQ-020 D/E register SHALL have no enable; it loads D-stage values every cycle when flushE=0.
REQ-021 When flushE=1, D/E SHALL load a bubble: ctrlE all-zero (no regwrite, memwrite, memtoreg, branch), rsE=rtE=rdE=0, data fields 0, validE=0.
REQ-022 validE SHALL equal validD of the previous cycle when flushE=0.
REQ-023 Bubble SHALL carry rsE=rtE=0 so that downstream forwarding and load-use detection never match it.
REQ-024 Latency: F-to-D and D-to-E SHALL each be exactly one cycle when unstalled.
REQ-025 stallcnt SHALL increment by 1 on each cycle with stallD=1; flushcnt on each cycle with flushE=1 or an F/D redirect clear.
REQ-026 Counters SHALL saturate at 2^CNT_W-1, never wrap.
REQ-027 A stall and redirect in the same cycle counts once in stallcnt and not in flushcnt.
REQ-028 All outputs SHALL be registered; no combinational input-to-output path.

Reset
REQ-029 On reset=0 at a rising edge: pcF=RESET_PC; F/D and D/E fields, validD, validE, ctrlE = 0; counters = 0.
REQ-030 Reset SHALL override stall, flush and redirect in the same cycle.
REQ-031 First cycle after reset release SHALL fetch from RESET_PC with validD=0 until the first load of F/D.

Structure
REQ-032 ctrl_t (regwrite, memtoreg, memwrite, branch, bne, alusrc, regdst, alucontrol[2:0]) and CTRL_NOP constant SHALL live in shared package mips_pkg.
REQ-033 One sub-module flopenrc (parameterised width; enable, synchronous clear, synchronous active-low reset) SHALL implement every pipeline register.
REQ-034 Counters SHALL be implemented inline, not as a separate module.

Verification
REQ-035 Reset: hold reset=0 two cycles with stallF=1, flushE=1 -> pcF=0, validD=validE=0, counters 0.
REQ-036 Free run: pcnextF=4,8,12 in consecutive cycles, no stalls -> pcF tracks with 1-cycle lag; instrD one cycle later; validE=1 two cycles after first fetch.
REQ-037 Load-use: stallF=stallD=flushE=1 for one cycle -> pcF and instrD held, ctrlE.regwrite=0, rsE=0, validE=0, stallcnt=1, flushcnt=1.
REQ-038 Taken branch: pcsrcD=1, stallD=0 -> next cycle instrD=0, validD=0, flushcnt=1; pcF=branch target from pcnextF.
REQ-039 Stall+branch: pcsrcD=1 and stallD=1 together -> instrD held, validD unchanged, stallcnt+1, flushcnt unchanged.
REQ-040 Saturation: CNT_W=4, stallD=1 for 20 cycles -> stallcnt reaches 15 and stays 15.
